mac_accumulator: RTL and testbench

- Downstream consumer of the radix-4 Booth multiplier. It takes each signed product the multiplier finishes and adds it into a wide signed accumulator.
- After a programmed number of products it presents a dot-product/MAC result with a done pulse.
- It detects product completion from the multiplier's `ready` level, so a held `ready` is counted exactly once.
- It provides optional saturation and sticky overflow/orphan flags.

---
 rtl/mac_accumulator.sv | 145 ++++++++++++++
 tb/tb_mac_accumulator.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// Signed multiply-accumulate back end: sums a programmed number of products from a
// level-ready multiplier into a wide accumulator, with optional saturation.
module mac_accumulator #(
  parameter int PROD_W   = 16,
  parameter int ACC_W    = 24,
  parameter int CNT_W    = 8,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              start_acc,
  input  logic [CNT_W-1:0]  n_terms,
  input  logic              prod_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              busy,
  output logic              done,
  output logic              acc_valid,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  term_cnt,
  output logic              ovf,
  output logic              orphan
);

  localparam int EXT_W = ACC_W + 1 - PROD_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   target_q;
  logic               busy_q;
  logic               done_q;
  logic               valid_q;
  logic               ovf_q;
  logic               orphan_q;
  logic               prev_ready_q;

  logic               prod_event;
  logic [ACC_W:0]     sum_d;
  logic               ovf_d;
  logic [ACC_W-1:0]   acc_d;
  logic [CNT_W-1:0]   cnt_d;

  // A held ready level counts once: only a low-to-high transition is a new product.
  assign prod_event = prod_ready & ~prev_ready_q;

  // One guard bit above the accumulator; the sign and guard bits disagree on overflow.
  always_comb begin
    sum_d = {acc_q[ACC_W-1], acc_q} + {{EXT_W{prod[PROD_W-1]}}, prod};
    ovf_d = sum_d[ACC_W] ^ sum_d[ACC_W-1];
    acc_d = sum_d[ACC_W-1:0];
    if (ovf_d && (SATURATE != 0)) begin
      acc_d = sum_d[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: all state below is written with <= so every register samples the
  // pre-edge values, regardless of statement order inside the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      target_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
      ovf_q        <= 1'b0;
      orphan_q     <= 1'b0;
      prev_ready_q <= 1'b0;
    end else if (clr) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      target_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
      ovf_q        <= 1'b0;
      orphan_q     <= 1'b0;
      prev_ready_q <= 1'b0;
    end else begin
      prev_ready_q <= prod_ready;
      done_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_acc) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            orphan_q <= 1'b0;
            valid_q  <= 1'b0;
            if (n_terms != '0) begin
              target_q <= n_terms;
              busy_q   <= 1'b1;
              state_q  <= S_ACCUM;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end else if (prod_event) begin
            orphan_q <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (prod_event) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (ovf_d) ovf_q <= 1'b1;
            if (cnt_d == target_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          valid_q <= 1'b1;
          state_q <= S_IDLE;
          if (prod_event) orphan_q <= 1'b1;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign acc_valid = valid_q;
  assign acc_out   = acc_q;
  assign term_cnt  = cnt_q;
  assign ovf       = ovf_q;
  assign orphan    = orphan_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: three instances (default, 17-bit saturating, 17-bit wrapping)
// share one stimulus stream and are compared against an arithmetic reference model.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        start_acc;
  logic [7:0]  n_terms;
  logic        prod_ready;
  logic [15:0] prod;

  logic [2:0]  busy_w, done_w, valid_w, ovf_w, orphan_w;
  logic [7:0]  cnt_w [3];
  logic [23:0] acc0;
  logic [16:0] acc1, acc2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mac_accumulator u_dflt (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start_acc(start_acc), .n_terms(n_terms),
    .prod_ready(prod_ready), .prod(prod), .busy(busy_w[0]), .done(done_w[0]),
    .acc_valid(valid_w[0]), .acc_out(acc0), .term_cnt(cnt_w[0]), .ovf(ovf_w[0]),
    .orphan(orphan_w[0]));

  mac_accumulator #(.ACC_W(17), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start_acc(start_acc), .n_terms(n_terms),
    .prod_ready(prod_ready), .prod(prod), .busy(busy_w[1]), .done(done_w[1]),
    .acc_valid(valid_w[1]), .acc_out(acc1), .term_cnt(cnt_w[1]), .ovf(ovf_w[1]),
    .orphan(orphan_w[1]));

  mac_accumulator #(.ACC_W(17), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start_acc(start_acc), .n_terms(n_terms),
    .prod_ready(prod_ready), .prod(prod), .busy(busy_w[2]), .done(done_w[2]),
    .acc_valid(valid_w[2]), .acc_out(acc2), .term_cnt(cnt_w[2]), .ovf(ovf_w[2]),
    .orphan(orphan_w[2]));

  // Reference model: plain integer arithmetic on the documented rules.
  typedef struct {
    int     st;     // 0 idle, 1 accumulating, 2 done
    longint acc;
    int     cnt;
    int     tgt;
    bit     ovf;
    bit     orph;
    bit     valid;
    bit     prev;
  } mdl_t;

  mdl_t m [3];
  int   acc_w_of [3] = '{24, 17, 17};
  bit   sat_of   [3] = '{1'b1, 1'b1, 1'b0};

  function automatic longint dut_acc(int i);
    case (i)
      0:       return longint'($signed(acc0));
      1:       return longint'($signed(acc1));
      default: return longint'($signed(acc2));
    endcase
  endfunction

  function automatic longint wrap(longint s, int w);
    longint full = longint'(1) << w;
    longint half = full >> 1;
    return ((s + half) % full + full) % full - half;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m[i] = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
  endfunction

  function automatic void model_step();
    for (int i = 0; i < 3; i++) begin
      bit     ev  = prod_ready && !m[i].prev;
      longint hi  = (longint'(1) << (acc_w_of[i] - 1)) - 1;
      longint lo  = -(longint'(1) << (acc_w_of[i] - 1));
      longint s;
      if (clr) begin
        m[i] = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        continue;
      end
      case (m[i].st)
        0: begin
          if (start_acc) begin
            m[i].acc = 0; m[i].cnt = 0; m[i].ovf = 0; m[i].orph = 0; m[i].valid = 0;
            if (n_terms != 0) begin
              m[i].tgt = int'(n_terms);
              m[i].st  = 1;
            end else begin
              m[i].st = 2;
            end
          end else if (ev) begin
            m[i].orph = 1;
          end
        end
        1: begin
          if (ev) begin
            s = m[i].acc + longint'($signed(prod));
            if (s > hi || s < lo) begin
              m[i].ovf = 1;
              m[i].acc = sat_of[i] ? ((s > hi) ? hi : lo) : wrap(s, acc_w_of[i]);
            end else begin
              m[i].acc = s;
            end
            m[i].cnt++;
            if (m[i].cnt == m[i].tgt) m[i].st = 2;
          end
        end
        default: begin
          m[i].valid = 1;
          m[i].st    = 0;
          if (ev) m[i].orph = 1;
        end
      endcase
      m[i].prev = prod_ready;
    end
  endfunction

  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d.busy", i),   longint'(busy_w[i]),   longint'(m[i].st == 1));
      check($sformatf("u%0d.done", i),   longint'(done_w[i]),   longint'(m[i].st == 2));
      check($sformatf("u%0d.valid", i),  longint'(valid_w[i]),  longint'(m[i].valid));
      check($sformatf("u%0d.acc", i),    dut_acc(i),            m[i].acc);
      check($sformatf("u%0d.cnt", i),    longint'(cnt_w[i]),    longint'(m[i].cnt));
      check($sformatf("u%0d.ovf", i),    longint'(ovf_w[i]),    longint'(m[i].ovf));
      check($sformatf("u%0d.orphan", i), longint'(orphan_w[i]), longint'(m[i].orph));
    end
  endtask

  // Inputs are applied at the falling edge; outputs are compared at the next falling edge.
  task automatic cyc(bit st, int n, bit rdy, longint p, bit c = 1'b0);
    start_acc  = st;
    n_terms    = 8'(n);
    prod_ready = rdy;
    prod       = 16'(p);
    clr        = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse(longint p);
    cyc(1'b0, 0, 1'b1, p);
    cyc(1'b0, 0, 1'b0, 0);
  endtask

  typedef struct {
    bit     st;
    int     n;
    bit     rdy;
    longint p;
    bit     e_busy;
    bit     e_done;
    bit     e_valid;
    longint e_acc;
    int     e_cnt;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 1ms", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; start_acc = 1'b0; n_terms = '0; prod_ready = 1'b0; prod = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset.acc", dut_acc(0), 0);
    check("reset.busy", longint'(busy_w[0]), 0);
    check("reset.valid", longint'(valid_w[0]), 0);
    rst_n = 1'b1;
    cyc(1'b0, 0, 1'b0, 0);

    // Five-term dot product from the multiplier: 21 - 20 - 20 + 49 + 225 = 255.
    tbl[0]  = '{1'b1, 5, 1'b0,    0, 1'b1, 1'b0, 1'b0,   0, 0};
    tbl[1]  = '{1'b0, 0, 1'b1,   21, 1'b1, 1'b0, 1'b0,  21, 1};
    tbl[2]  = '{1'b0, 0, 1'b0,    0, 1'b1, 1'b0, 1'b0,  21, 1};
    tbl[3]  = '{1'b0, 0, 1'b1,  -20, 1'b1, 1'b0, 1'b0,   1, 2};
    tbl[4]  = '{1'b0, 0, 1'b0,    0, 1'b1, 1'b0, 1'b0,   1, 2};
    tbl[5]  = '{1'b0, 0, 1'b1,  -20, 1'b1, 1'b0, 1'b0, -19, 3};
    tbl[6]  = '{1'b0, 0, 1'b0,    0, 1'b1, 1'b0, 1'b0, -19, 3};
    tbl[7]  = '{1'b0, 0, 1'b1,   49, 1'b1, 1'b0, 1'b0,  30, 4};
    tbl[8]  = '{1'b0, 0, 1'b0,    0, 1'b1, 1'b0, 1'b0,  30, 4};
    tbl[9]  = '{1'b0, 0, 1'b1,  225, 1'b0, 1'b1, 1'b0, 255, 5};
    tbl[10] = '{1'b0, 0, 1'b0,    0, 1'b0, 1'b0, 1'b1, 255, 5};
    for (int k = 0; k < 11; k++) begin
      cyc(tbl[k].st, tbl[k].n, tbl[k].rdy, tbl[k].p);
      check($sformatf("tbl%0d.busy", k),  longint'(busy_w[0]),  longint'(tbl[k].e_busy));
      check($sformatf("tbl%0d.done", k),  longint'(done_w[0]),  longint'(tbl[k].e_done));
      check($sformatf("tbl%0d.valid", k), longint'(valid_w[0]), longint'(tbl[k].e_valid));
      check($sformatf("tbl%0d.acc", k),   dut_acc(0),           tbl[k].e_acc);
      check($sformatf("tbl%0d.cnt", k),   longint'(cnt_w[0]),   longint'(tbl[k].e_cnt));
    end
    check("dot.ovf", longint'(ovf_w[0]), 0);

    // Ready already high on entry: the held 100 must not be counted.
    cyc(1'b0, 0, 1'b1, 100);
    cyc(1'b1, 1, 1'b1, 100);
    repeat (3) cyc(1'b0, 0, 1'b1, 100);
    cyc(1'b0, 0, 1'b0, 0);
    cyc(1'b0, 0, 1'b1, -3);
    check("held.acc", dut_acc(0), -3);
    check("held.cnt", longint'(cnt_w[0]), 1);
    check("held.done", longint'(done_w[0]), 1);
    cyc(1'b0, 0, 1'b0, 0);

    // Positive then negative overflow on the 17-bit instances.
    cyc(1'b1, 3, 1'b0, 0);
    repeat (3) pulse(32767);
    check("satp.acc", dut_acc(1), 65535);
    check("satp.ovf", longint'(ovf_w[1]), 1);
    check("wrap.acc", dut_acc(2), -32771);
    check("wrap.ovf", longint'(ovf_w[2]), 1);
    check("wide.acc", dut_acc(0), 98301);
    check("wide.ovf", longint'(ovf_w[0]), 0);
    cyc(1'b1, 3, 1'b0, 0);
    repeat (3) pulse(-32768);
    check("satn.acc", dut_acc(1), -65536);
    check("satn.ovf", longint'(ovf_w[1]), 1);
    check("wrapn.acc", dut_acc(2), 32768);

    // Start during a run is ignored; a product in IDLE only flags orphan.
    cyc(1'b1, 2, 1'b0, 0);
    pulse(10);
    cyc(1'b1, 7, 1'b0, 0);
    check("ign.busy", longint'(busy_w[0]), 1);
    cyc(1'b0, 0, 1'b1, 5);
    check("ign.done", longint'(done_w[0]), 1);
    check("ign.cnt", longint'(cnt_w[0]), 2);
    cyc(1'b0, 0, 1'b0, 0);
    pulse(999);
    check("orph.flag", longint'(orphan_w[0]), 1);
    check("orph.acc", dut_acc(0), 15);

    // Zero-term run.
    cyc(1'b1, 0, 1'b0, 0);
    check("zero.done", longint'(done_w[0]), 1);
    check("zero.acc", dut_acc(0), 0);
    cyc(1'b0, 0, 1'b0, 0);
    check("zero.valid", longint'(valid_w[0]), 1);

    // Synchronous clear mid-run.
    cyc(1'b1, 5, 1'b0, 0);
    pulse(40); pulse(2);
    cyc(1'b0, 0, 1'b0, 0, 1'b1);
    check("clr.acc", dut_acc(0), 0);
    check("clr.busy", longint'(busy_w[0]), 0);
    cyc(1'b0, 0, 1'b0, 0);
    check("clr.nodone", longint'(done_w[0]), 0);

    // Asynchronous reset mid-run, asserted between clock edges.
    cyc(1'b1, 5, 1'b0, 0);
    pulse(40); pulse(2);
    #2 rst_n = 1'b0;
    #1;
    check("arst.acc", dut_acc(0), 0);
    check("arst.cnt", longint'(cnt_w[0]), 0);
    check("arst.busy", longint'(busy_w[0]), 0);
    model_reset();
    @(negedge clk);
    check("arst.nodone", longint'(done_w[0]), 0);
    rst_n = 1'b1;
    cyc(1'b0, 0, 1'b0, 0);

    // Randomized traffic against the model, biased toward extreme products.
    for (int k = 0; k < 1500; k++) begin
      longint p;
      case ($urandom_range(3))
        0:       p = 32767;
        1:       p = -32768;
        default: p = longint'($signed(16'($urandom)));
      endcase
      cyc(($urandom_range(11) == 0), int'($urandom_range(6)), 1'($urandom), p,
          ($urandom_range(99) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
